// File: rtl/m_lod32_pipe.sv
// Two-stage pipelined leading-one detector for the Mitchell log front end.
// S1 registers per-byte nonzero flags and local indices. S2 picks the top nonzero byte and forms K.
module m_lod32_pipe #(
    parameter int wl_N = 32,
    parameter int wl_k = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [wl_N-1:0] N,
    input  logic            N_VALID,
    output logic            N_READY,
    output logic [wl_N-1:0] N_OUT,
    output logic [wl_k-1:0] K,
    output logic            ZERO,
    output logic            OUT_VALID,
    input  logic            OUT_READY
);

    localparam int NB = wl_N / 8;

    logic [wl_N-1:0]     s1_n;
    logic [NB-1:0]       s1_nz;
    logic [NB-1:0][2:0]  s1_pos;
    logic                s1_valid;
    logic                s2_valid;

    logic [NB-1:0]       byte_nz;
    logic [NB-1:0][2:0]  byte_pos;
    logic [wl_k-1:0]     sel_k;
    logic                sel_zero;

    logic s2_free;
    logic s1_adv;
    logic in_xfer;
    logic out_xfer;

    // Highest set bit wins because later iterations overwrite earlier ones.
    function automatic logic [2:0] byte_lod(input logic [7:0] b);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign s2_free   = !s2_valid || OUT_READY;
    assign s1_adv    = s1_valid && s2_free;
    assign N_READY   = !s1_valid || s2_free;
    assign in_xfer   = N_VALID && N_READY;
    assign out_xfer  = s2_valid && OUT_READY;
    assign OUT_VALID = s2_valid;

    always_comb begin
        byte_nz  = '0;
        byte_pos = '0;
        for (int b = 0; b < NB; b++) begin
            byte_nz[b]  = |N[8*b +: 8];
            byte_pos[b] = byte_lod(N[8*b +: 8]);
        end
    end

    always_comb begin
        sel_k = '0;
        for (int b = 0; b < NB; b++) begin
            if (s1_nz[b]) sel_k = {2'(b), s1_pos[b]};
        end
        sel_zero = ~|s1_nz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_n     <= '0;
            s1_nz    <= '0;
            s1_pos   <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_n     <= N;
                s1_nz    <= byte_nz;
                s1_pos   <= byte_pos;
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Output registers only change when S1 hands over, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N_OUT    <= '0;
            K        <= '0;
            ZERO     <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                N_OUT    <= s1_n;
                K        <= sel_k;
                ZERO     <= sel_zero;
                s2_valid <= 1'b1;
            end else if (out_xfer) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m_lod32_pipe.sv
// Scoreboard bench for m_lod32_pipe: accepted words are modelled and queued,
// and a monitor compares every presented output against the queue head.
module tb_m_lod32_pipe;

    typedef struct {
        logic [31:0] n;
        logic [4:0]  k;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] N;
    logic        N_VALID;
    logic        N_READY;
    logic [31:0] N_OUT;
    logic [4:0]  K;
    logic        ZERO;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;

    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    bit   check_lat = 1'b0;
    exp_t q[$];

    m_lod32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .N         (N),
        .N_VALID   (N_VALID),
        .N_READY   (N_READY),
        .N_OUT     (N_OUT),
        .K         (K),
        .ZERO      (ZERO),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: scan from the MSB down for the first 1.
    function automatic exp_t ref_model(input logic [31:0] w, input int c);
        exp_t e;
        e.n    = w;
        e.k    = 5'd0;
        e.zero = (w == 32'd0);
        e.cyc  = c;
        for (int i = 31; i >= 0; i--) begin
            if (w[i]) begin
                e.k = 5'(i);
                break;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            errors++;
            $display("[TB] FAIL unexpected_output: got N_OUT=%h K=%0d ZERO=%0d, expected no output", N_OUT, K, ZERO);
            return;
        end
        e = q[0];
        tests++;
        if (N_OUT !== e.n || K !== e.k || ZERO !== e.zero) begin
            errors++;
            $display("[TB] FAIL output: got N_OUT=%h K=%0d ZERO=%0d, expected N_OUT=%h K=%0d ZERO=%0d",
                     N_OUT, K, ZERO, e.n, e.k, e.zero);
        end
        if (OUT_READY) begin
            if (check_lat) begin
                tests++;
                if (cyc - e.cyc != 2) begin
                    errors++;
                    $display("[TB] FAIL latency: got %0d clocks, expected 2 for N=%h", cyc - e.cyc, e.n);
                end
            end
            void'(q.pop_front());
        end
    endtask

    // Input transfers are observed mid-cycle, when inputs and N_READY are settled.
    initial forever begin
        @(negedge clk);
        if (rst_n && N_VALID && N_READY) q.push_back(ref_model(N, cyc));
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && OUT_VALID) checkOutput();
    end

    // OUT_READY pattern: 0 = always ready, 1 = alternating, otherwise stalled.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = ~OUT_READY;
            default: OUT_READY = 1'b0;
        endcase
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Called at posedge+1; returns at posedge+1 after the word has transferred.
    task automatic applyStimulus(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        N = w;
        N_VALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (N_READY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            errors++;
            $display("[TB] FAIL accept_timeout: got N_READY=0 for 200 cycles, expected acceptance of %h", w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        N_VALID = 1'b0;
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d words outstanding, expected 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        N       = '0;
        N_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(OUT_VALID), 32'd0);
        check("reset_k", 32'(K), 32'd0);
        check("reset_n_out", N_OUT, 32'd0);
        check("reset_zero", 32'(ZERO), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_n_ready", 32'(N_READY), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] unstalled stream");
        check_lat = 1'b1;
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h8000_0000);
        applyStimulus(32'h0001_2345);
        applyStimulus(32'h00FF_0000);
        drain();

        $display("[TB] zero input");
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_0080);
        drain();

        $display("[TB] backpressure");
        check_lat  = 1'b0;
        ready_mode = 2;
        applyStimulus(32'h0000_0010);
        applyStimulus(32'h0000_0100);
        N       = 32'h0000_1000;
        N_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_n_ready", 32'(N_READY), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        applyStimulus(32'h0000_1000);
        drain();

        $display("[TB] alternating OUT_READY random stream");
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom >> $urandom_range(0, 32));
        end
        drain();
        ready_mode = 0;
        @(posedge clk);
        #1;

        $display("[TB] reset mid-operation");
        ready_mode = 2;
        applyStimulus(32'h0000_0011);
        applyStimulus(32'h0000_0022);
        N_VALID = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(OUT_VALID), 32'd0);
        check("midreset_k", 32'(K), 32'd0);
        check("midreset_n_out", N_OUT, 32'd0);
        check("midreset_zero", 32'(ZERO), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        ready_mode = 0;
        rst_n = 1'b1;
        #1;
        check("release_n_ready", 32'(N_READY), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_out_valid", 32'(OUT_VALID), 32'd0);
        end
        @(posedge clk);
        #1;
        check_lat = 1'b1;
        applyStimulus(32'h4000_0000);
        drain();

        $display("[TB] single-bit sweep");
        for (int i = 0; i < 32; i++) applyStimulus(32'd1 << i);
        for (int i = 0; i < 32; i++) applyStimulus((32'd1 << i) | 32'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
